// File: rtl/pin_entry_pkg.sv
// pin_entry_pkg: shared types and constants for the PIN entry controller.
//   state_t     - controller FSM states
//   PIN_W       - assembled code width (level nibble + id nibble)
//   DIGIT_W     - width of one keypad digit
//   CNT_W       - width of the digits-held counter
//   FAIL_W      - width of the consecutive-failure counter (LOCKOUT_EN builds)
package pin_entry_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HALF    = 3'd1,
    S_REQ     = 3'd2,
    S_DONE    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  localparam int PIN_W   = 8;
  localparam int DIGIT_W = 4;
  localparam int CNT_W   = 2;
  localparam int FAIL_W  = 2;

  localparam logic [CNT_W-1:0]  CNT_NONE   = 2'd0;
  localparam logic [CNT_W-1:0]  CNT_ONE    = 2'd1;
  localparam logic [CNT_W-1:0]  CNT_TWO    = 2'd2;
  // Third consecutive failure triggers lockout.
  localparam logic [FAIL_W-1:0] FAIL_LIMIT = 2'd3;

endpackage

// File: rtl/pin_entry_ctrl_cycle_timer.sv
// cycle_timer: saturating cycle counter used for every timeout in the controller.
//   clk     - system clock
//   rst     - synchronous active-low reset
//   load    - restart the count at zero (held while the owning state is inactive)
//   enable  - count while high
//   expired - high during the LIMIT-th enabled cycle after a load
// The counter is $clog2(LIMIT) bits wide and stops at LIMIT-1, so it never wraps.
module cycle_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/pin_entry_ctrl.sv
// pin_entry_ctrl: collects a two-digit keypad code and requests access from a lock.
// Optional feature macro: LOCKOUT_EN (consecutive-failure lockout).
// Ports:
//   clk, rst                 - clock, synchronous active-low reset
//   key_valid, key_code      - one-cycle digit strobe and its 4-bit value
//   key_clear                - one-cycle strobe discarding a partial entry
//   pin                      - assembled code {level, id}
//   req_access               - access request to the lock
//   lock_open, deny_access,
//   alarm                    - lock response levels
//   busy                     - controller not idle
//   granted, denied,
//   timed_out                - one-cycle result pulses
//   digit_cnt                - digits currently held (0..2)
//   locked_out               - lockout in progress (0 without LOCKOUT_EN)
//   fsm_state                - current FSM state, for observation
// Handshake: req_access rises on the cycle after the second digit and stays high
// until the first cycle in which any response level is seen (or the response
// timeout expires); it drops together with the result pulse on the next cycle.
module pin_entry_ctrl
  import pin_entry_pkg::*;
#(
  parameter int unsigned RESP_TIMEOUT   = 1024,
  parameter int unsigned ENTRY_TIMEOUT  = 50_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 500_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_code,
  input  logic               key_clear,
  output logic [PIN_W-1:0]   pin,
  output logic               req_access,
  input  logic               lock_open,
  input  logic               deny_access,
  input  logic               alarm,
  output logic               busy,
  output logic               granted,
  output logic               denied,
  output logic               timed_out,
  output logic [CNT_W-1:0]   digit_cnt,
  output logic               locked_out,
  output state_t             fsm_state
);

  state_t state;
  logic   entry_expired;
  logic   resp_expired;
  logic   lock_expired;

  // Each timer is held at zero outside its state, so it restarts on entry.
  cycle_timer #(.LIMIT(ENTRY_TIMEOUT)) u_entry_timer (
    .clk(clk), .rst(rst), .load(state != S_HALF),
    .enable(state == S_HALF), .expired(entry_expired)
  );

  cycle_timer #(.LIMIT(RESP_TIMEOUT)) u_resp_timer (
    .clk(clk), .rst(rst), .load(state != S_REQ),
    .enable(state == S_REQ), .expired(resp_expired)
  );

  cycle_timer #(.LIMIT(LOCKOUT_CYCLES)) u_lock_timer (
    .clk(clk), .rst(rst), .load(state != S_LOCKOUT),
    .enable(state == S_LOCKOUT), .expired(lock_expired)
  );

`ifdef LOCKOUT_EN
  logic [FAIL_W-1:0] fail_cnt;
  logic              locked_q;
  assign locked_out = locked_q;
`else
  assign locked_out = 1'b0;
`endif

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      pin        <= '0;
      digit_cnt  <= CNT_NONE;
      req_access <= 1'b0;
      busy       <= 1'b0;
      granted    <= 1'b0;
      denied     <= 1'b0;
      timed_out  <= 1'b0;
`ifdef LOCKOUT_EN
      fail_cnt   <= '0;
      locked_q   <= 1'b0;
`endif
    end else begin
      granted   <= 1'b0;
      denied    <= 1'b0;
      timed_out <= 1'b0;
      case (state)
        S_IDLE: begin
          // key_clear outranks a simultaneous digit.
          if (key_clear) begin
            pin       <= '0;
            digit_cnt <= CNT_NONE;
          end else if (key_valid) begin
            pin       <= {key_code, {DIGIT_W{1'b0}}};
            digit_cnt <= CNT_ONE;
            busy      <= 1'b1;
            state     <= S_HALF;
          end
        end
        S_HALF: begin
          if (key_clear || (!key_valid && entry_expired)) begin
            pin       <= '0;
            digit_cnt <= CNT_NONE;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else if (key_valid) begin
            pin[DIGIT_W-1:0] <= key_code;
            digit_cnt        <= CNT_TWO;
            req_access       <= 1'b1;
            state            <= S_REQ;
          end
        end
        S_REQ: begin
          // alarm and deny_access both report as denied, ahead of lock_open.
          if (alarm || deny_access || lock_open || resp_expired) begin
            req_access <= 1'b0;
            state      <= S_DONE;
            if (alarm || deny_access) begin
              denied <= 1'b1;
            end else if (lock_open) begin
              granted <= 1'b1;
            end else begin
              timed_out <= 1'b1;
            end
`ifdef LOCKOUT_EN
            if (!alarm && !deny_access && lock_open) begin
              fail_cnt <= '0;
            end else if (fail_cnt != FAIL_LIMIT) begin
              fail_cnt <= fail_cnt + 1'b1;
            end
`endif
          end
        end
        S_DONE: begin
          pin       <= '0;
          digit_cnt <= CNT_NONE;
`ifdef LOCKOUT_EN
          if (fail_cnt == FAIL_LIMIT) begin
            locked_q <= 1'b1;
            state    <= S_LOCKOUT;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
`else
          busy  <= 1'b0;
          state <= S_IDLE;
`endif
        end
        S_LOCKOUT: begin
          if (lock_expired) begin
            busy  <= 1'b0;
            state <= S_IDLE;
`ifdef LOCKOUT_EN
            locked_q <= 1'b0;
            fail_cnt <= '0;
`endif
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// tb_pin_entry_ctrl: self-checking bench for pin_entry_ctrl.
// Result expectations {kind, pin} are queued as responses are driven and
// popped by a monitor when a result pulse appears.
module tb_pin_entry_ctrl;
  import pin_entry_pkg::*;

  localparam int unsigned RESP_T  = 8;
  localparam int unsigned ENTRY_T = 12;
  localparam int unsigned LOCK_T  = 16;

  localparam logic [1:0] K_GRANT = 2'd1;
  localparam logic [1:0] K_DENY  = 2'd2;
  localparam logic [1:0] K_TMO   = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       key_clear = 1'b0;
  logic [7:0] pin;
  logic       req_access;
  logic       lock_open = 1'b0;
  logic       deny_access = 1'b0;
  logic       alarm = 1'b0;
  logic       busy, granted, denied, timed_out, locked_out;
  logic [1:0] digit_cnt;
  state_t     fsm_state;

  int checks   = 0;
  int failures = 0;
  int n_push   = 0;
  int n_pop    = 0;
  logic [9:0] exp_q[$];

  pin_entry_ctrl #(
    .RESP_TIMEOUT(RESP_T), .ENTRY_TIMEOUT(ENTRY_T), .LOCKOUT_CYCLES(LOCK_T)
  ) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .key_clear(key_clear), .pin(pin), .req_access(req_access),
    .lock_open(lock_open), .deny_access(deny_access), .alarm(alarm),
    .busy(busy), .granted(granted), .denied(denied), .timed_out(timed_out),
    .digit_cnt(digit_cnt), .locked_out(locked_out), .fsm_state(fsm_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Result monitor: pops one expectation per observed pulse.
  always @(negedge clk) begin
    if (rst && (granted || denied || timed_out)) begin
      logic [1:0] kind;
      kind = granted ? K_GRANT : (denied ? K_DENY : K_TMO);
      check("pulse_onehot", 32'($countones({granted, denied, timed_out})), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'({kind, pin}), 0);
      end else begin
        n_pop++;
        check("result", 32'({kind, pin}), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic enter_pin(input logic [3:0] a, input logic [3:0] b);
    key_valid = 1'b1; key_code = a;
    step();
    check("first_pin", 32'(pin), 32'({a, 4'h0}));
    check("first_cnt", 32'(digit_cnt), 1);
    check("first_state", 32'(fsm_state), 32'(S_HALF));
    key_code = b;
    step();
    key_valid = 1'b0;
    check("req_rise", 32'(req_access), 1);
    check("second_pin", 32'(pin), 32'({a, b}));
    check("second_cnt", 32'(digit_cnt), 2);
  endtask

  task automatic respond(input logic o, input logic d, input logic al,
                         input logic [1:0] kind, input logic [7:0] p);
    exp_q.push_back({kind, p});
    n_push++;
    lock_open = o; deny_access = d; alarm = al;
    step();
    lock_open = 1'b0; deny_access = 1'b0; alarm = 1'b0;
    check("req_drop", 32'(req_access), 0);
    check("done_state", 32'(fsm_state), 32'(S_DONE));
  endtask

  task automatic finish_idle();
    step();
    check("idle_pin", 32'(pin), 0);
    check("idle_cnt", 32'(digit_cnt), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_state", 32'(fsm_state), 32'(S_IDLE));
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 32'({pin, req_access, busy, granted, denied, timed_out, digit_cnt, locked_out}), 0);
    check("reset_state", 32'(fsm_state), 32'(S_IDLE));
  endtask

  initial begin
    logic [3:0] a, b;
    int kind;

    // reset
    rst = 1'b0;
    repeat (3) step();
    check_all_zero("reset_outputs");
    rst = 1'b1;
    step();

    // 0x7,0x7 granted; keys ignored while waiting in REQ
    enter_pin(4'h7, 4'h7);
    key_valid = 1'b1; key_code = 4'hF; key_clear = 1'b1;
    step();
    key_valid = 1'b0; key_clear = 1'b0;
    check("req_hold", 32'(req_access), 1);
    check("req_pin_stable", 32'(pin), 32'h77);
    check("req_cnt_stable", 32'(digit_cnt), 2);
    step();
    respond(1'b1, 1'b0, 1'b0, K_GRANT, 8'h77);
    finish_idle();

    // 0xA,0x5 with deny, alarm and lock_open together -> denied only
    enter_pin(4'hA, 4'h5);
    respond(1'b1, 1'b1, 1'b1, K_DENY, 8'hA5);
    finish_idle();

    // 0x1,0x2 with no response -> timed_out after RESP_T REQ cycles
    enter_pin(4'h1, 4'h2);
    for (int i = 1; i < int'(RESP_T); i++) begin
      step();
      check("tmo_req_hold", 32'(req_access), 1);
      check("tmo_early", 32'(timed_out), 0);
    end
    exp_q.push_back({K_TMO, 8'h12});
    n_push++;
    step();
    check("tmo_pulse", 32'(timed_out), 1);
    check("tmo_req_drop", 32'(req_access), 0);
    finish_idle();

    // key 0x3, then key_clear and key_valid together -> IDLE, nothing requested
    key_valid = 1'b1; key_code = 4'h3;
    step();
    key_clear = 1'b1; key_code = 4'h9;
    step();
    key_valid = 1'b0; key_clear = 1'b0;
    check("clear_cnt", 32'(digit_cnt), 0);
    check("clear_pin", 32'(pin), 0);
    check("clear_state", 32'(fsm_state), 32'(S_IDLE));
    step();
    check("clear_no_req", 32'(req_access), 0);

    // entry timeout in HALF: quiet return to IDLE
    key_valid = 1'b1; key_code = 4'h4;
    step();
    key_valid = 1'b0;
    for (int i = 1; i < int'(ENTRY_T); i++) begin
      step();
      check("entry_wait_busy", 32'(busy), 1);
    end
    finish_idle();

    // reset while requesting, then a normal entry
    enter_pin(4'h5, 4'h6);
    rst = 1'b0;
    step();
    check_all_zero("midreq_reset");
    rst = 1'b1;
    step();
    enter_pin(4'h8, 4'h9);
    respond(1'b1, 1'b0, 1'b0, K_GRANT, 8'h89);
    finish_idle();

    // random entries; a failure is always followed by a grant
    for (int i = 0; i < 6; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      kind = (i % 2 == 0) ? int'($urandom_range(0, 2)) : 0;
      enter_pin(a, b);
      repeat ($urandom_range(0, RESP_T - 2)) step();
      case (kind)
        0:       respond(1'b1, 1'b0, 1'b0, K_GRANT, {a, b});
        1:       respond(1'b0, 1'b1, 1'b0, K_DENY, {a, b});
        default: respond(1'b1, 1'b0, 1'b1, K_DENY, {a, b});
      endcase
      finish_idle();
    end

    // three consecutive denials
    for (int i = 0; i < 3; i++) begin
      enter_pin(4'hC, 4'(i));
      respond(1'b0, 1'b1, 1'b0, K_DENY, {4'hC, 4'(i)});
      if (i < 2) finish_idle();
    end
`ifdef LOCKOUT_EN
    step();
    check("lock_enter", 32'(locked_out), 1);
    check("lock_state", 32'(fsm_state), 32'(S_LOCKOUT));
    for (int i = 1; i < int'(LOCK_T); i++) begin
      key_valid = 1'b1; key_code = 4'($urandom_range(0, 15));
      key_clear = 1'($urandom_range(0, 1));
      step();
      check("lock_hold", 32'(locked_out), 1);
      check("lock_keys_ignored", 32'(digit_cnt), 0);
    end
    key_valid = 1'b0; key_clear = 1'b0;
    step();
    check("lock_release", 32'(locked_out), 0);
    check("lock_idle", 32'(fsm_state), 32'(S_IDLE));
    step();
`else
    finish_idle();
    check("no_lockout", 32'(locked_out), 0);
`endif

    // entry works normally afterwards
    enter_pin(4'h2, 4'hE);
    respond(1'b1, 1'b0, 1'b0, K_GRANT, 8'h2E);
    finish_idle();
    check("after_locked_out", 32'(locked_out), 0);

    step();
    step();
    check("queue_drained", 32'(exp_q.size()), 0);
    check("results_seen", 32'(n_pop), 32'(n_push));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
